// File: rtl/reg_bus_bridge_pkg.sv
// Shared definitions for the byte-stream register bus bridge.
// Holds the FSM state encoding, command byte field positions and the
// default response bytes.
package reg_bus_bridge_pkg;

  typedef enum logic [3:0] {
    ST_CMD,
    ST_IDX,
    ST_DHI,
    ST_DLO,
    ST_REQ,
    ST_ACCESS,
    ST_WAIT_RD,
    ST_RESP_HI,
    ST_RESP_LO,
    ST_ACK,
    ST_NAK
  } state_t;

  // Command byte layout: write flag, reserved field (must be zero), index[11:8]
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_RSVD_MSB  = 6;
  localparam int CMD_RSVD_LSB  = 4;
  localparam int CMD_IDX_MSB   = 3;
  localparam int CMD_IDX_LSB   = 0;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hA5;
  localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h15;

endpackage

// File: rtl/reg_bus_bridge_timeout.sv
// Inter-byte idle counter for the bridge frame receiver.
// expired is combinational: it is high during the TIMEOUT_CYCLES-th enabled idle cycle.
// clear (an accepted byte) or a low enable reloads the count to zero.
module bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  assign expired = enable & ~clear & (count == LAST);

  // Count idle cycles while enabled; reload to zero on a byte or when disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/reg_bus_bridge.sv
// Byte-stream command bridge acting as a second initiator on the register bus.
// Latency: last frame byte to strobe is 2 cycles with grant held; response bytes follow the access.
// Backpressure: rx_ready only while collecting a frame; tx_valid holds stable data until tx_ready.
module reg_bus_bridge
  import reg_bus_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 250000,
  parameter logic [7:0] ACK_BYTE       = DEFAULT_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEFAULT_NAK_BYTE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [11:0] register_index,
  output logic        register_read,
  output logic        register_write,
  output logic [15:0] register_write_value,
  input  logic [15:0] register_read_value
);

  state_t      state_q, state_d;
  logic        is_write_q;
  logic [11:0] idx_q;
  logic [15:0] data_q;
  logic [15:0] rd_q;

  logic rx_accept;
  logic cmd_bad;
  logic tmo_enable;
  logic tmo_expired;

  assign rx_accept  = rx_valid & rx_ready;
  assign cmd_bad    = |rx_data[CMD_RSVD_MSB:CMD_RSVD_LSB];
  assign tmo_enable = (state_q == ST_IDX) || (state_q == ST_DHI) || (state_q == ST_DLO);

  // Frame registers only change on accepted bytes, so index and write data
  // are naturally stable from REQ through ACCESS.
  assign register_index       = idx_q;
  assign register_write_value = data_q;

  bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (rx_accept),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CMD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all handshake/strobe outputs, decoded from the current state.
  always_comb begin
    state_d        = state_q;
    rx_ready       = 1'b0;
    tx_valid       = 1'b0;
    tx_data        = 8'h00;
    bus_req        = 1'b0;
    register_read  = 1'b0;
    register_write = 1'b0;
    case (state_q)
      ST_CMD: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = cmd_bad ? ST_NAK : ST_IDX;
      end
      ST_IDX: begin
        rx_ready = 1'b1;
        if (rx_valid)         state_d = is_write_q ? ST_DHI : ST_REQ;
        else if (tmo_expired) state_d = ST_CMD;
      end
      ST_DHI: begin
        rx_ready = 1'b1;
        if (rx_valid)         state_d = ST_DLO;
        else if (tmo_expired) state_d = ST_CMD;
      end
      ST_DLO: begin
        rx_ready = 1'b1;
        if (rx_valid)         state_d = ST_REQ;
        else if (tmo_expired) state_d = ST_CMD;
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Grant is no longer looked at: once started, the access completes.
        bus_req        = 1'b1;
        register_write = is_write_q;
        register_read  = ~is_write_q;
        state_d        = is_write_q ? ST_ACK : ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        bus_req = 1'b1;
        state_d = ST_RESP_HI;
      end
      ST_RESP_HI: begin
        tx_valid = 1'b1;
        tx_data  = rd_q[15:8];
        if (tx_ready) state_d = ST_RESP_LO;
      end
      ST_RESP_LO: begin
        tx_valid = 1'b1;
        tx_data  = rd_q[7:0];
        if (tx_ready) state_d = ST_CMD;
      end
      ST_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
        if (tx_ready) state_d = ST_CMD;
      end
      ST_NAK: begin
        tx_valid = 1'b1;
        tx_data  = NAK_BYTE;
        if (tx_ready) state_d = ST_CMD;
      end
      default: state_d = ST_CMD;
    endcase
  end

  // Frame assembly from accepted bytes, and read data capture in WAIT_RD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_write_q <= 1'b0;
      idx_q      <= 12'h000;
      data_q     <= 16'h0000;
      rd_q       <= 16'h0000;
    end else begin
      if (rx_accept) begin
        case (state_q)
          ST_CMD: begin
            // A command with reserved bits set is dropped without touching the frame.
            if (!cmd_bad) begin
              is_write_q   <= rx_data[CMD_WRITE_BIT];
              idx_q[11:8]  <= rx_data[CMD_IDX_MSB:CMD_IDX_LSB];
            end
          end
          ST_IDX:  idx_q[7:0]    <= rx_data;
          ST_DHI:  data_q[15:8]  <= rx_data;
          ST_DLO:  data_q[7:0]   <= rx_data;
          default: ;
        endcase
      end
      if (state_q == ST_WAIT_RD) rd_q <= register_read_value;
    end
  end

endmodule

// File: tb/tb_reg_bus_bridge.sv
// Directed bench for reg_bus_bridge with a frame-level model and per-cycle checker.
module tb_reg_bus_bridge;

  localparam int TMO = 16;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        bus_req;
  logic        bus_gnt = 1'b1;
  logic [11:0] register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value = 16'h0000;

  always #20 clk = ~clk;

  reg_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .register_index(register_index), .register_read(register_read),
    .register_write(register_write), .register_write_value(register_write_value),
    .register_read_value(register_read_value)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Power-on register contents, shared by the responder and the model.
  function automatic logic [15:0] init_val(input logic [11:0] a);
    case (a)
      12'h000: return 16'h5AC3;
      12'h002: return 16'h003F;
      12'h00A: return 16'h1111;
      default: return 16'h0000;
    endcase
  endfunction

  // Responder: registered read data, valid the cycle after the strobe.
  logic [15:0] rsp_mem [int];
  function automatic logic [15:0] rsp_rd(input logic [11:0] a);
    if (rsp_mem.exists(int'(a))) return rsp_mem[int'(a)];
    return init_val(a);
  endfunction
  always @(posedge clk) begin
    if (register_write) rsp_mem[int'(register_index)] = register_write_value;
    if (register_read) register_read_value <= rsp_rd(register_index);
  end

  // Frame-level model: expected bus accesses and expected tx bytes in order.
  typedef struct {
    bit          wr;
    logic [11:0] idx;
    logic [15:0] val;
  } acc_t;
  acc_t        exp_acc[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [15:0] model_mem [int];

  function automatic logic [15:0] model_rd(input logic [11:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return init_val(a);
  endfunction

  int total = 0;
  int bad = 0;
  int last_acc_cyc = 0;
  int last_strobe_cyc = 0;
  int strobe_count = 0;
  logic [11:0] last_idx = 12'h000;
  logic [15:0] last_val = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic       p_txv = 1'b0, p_txr = 1'b0, p_wr = 1'b0, p_rd = 1'b0, p2_rd = 1'b0, p_gnt = 1'b0;
    logic [7:0] p_txd = 8'h00;
    acc_t       a;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p_txv = 1'b0; p_wr = 1'b0; p_rd = 1'b0; p2_rd = 1'b0; p_gnt = 1'b0;
        continue;
      end
      if (rx_valid && rx_ready) last_acc_cyc = cyc;
      if (register_write || register_read) begin
        strobe_count++;
        last_strobe_cyc = cyc;
        last_idx = register_index;
        last_val = register_write_value;
        chk("strobe_expected", exp_acc.size() > 0, 1);
        if (exp_acc.size() > 0) begin
          a = exp_acc.pop_front();
          chk("strobe_kind", register_write, a.wr);
          chk("strobe_idx", register_index, a.idx);
          if (a.wr) chk("strobe_val", register_write_value, a.val);
        end
        chk("req_at_strobe", bus_req, 1);
        chk("gnt_before_strobe", p_gnt, 1);
      end
      if (p_wr)  chk("req_low_after_write", bus_req, 0);
      if (p_rd)  chk("req_high_in_wait_rd", bus_req, 1);
      if (p2_rd) chk("req_low_after_wait_rd", bus_req, 0);
      if (p_txv && !p_txr) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, p_txd);
      end
      if (tx_valid && tx_ready) begin
        tx_log.push_back(tx_data);
        chk("tx_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      chk("rx_blocked_when_busy", rx_ready & (bus_req | tx_valid), 0);
      p2_rd = p_rd;
      p_rd  = register_read;
      p_wr  = register_write;
      p_gnt = bus_req & bus_gnt;
      p_txv = tx_valid;
      p_txr = tx_ready;
      p_txd = tx_data;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 400) begin
        chk("rx_accept_timeout", rx_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] idx, input logic [15:0] v);
    exp_acc.push_back('{1'b1, idx, v});
    exp_tx.push_back(ACK);
    model_mem[int'(idx)] = v;
    send_byte({4'h8, idx[11:8]});
    send_byte(idx[7:0]);
    send_byte(v[15:8]);
    send_byte(v[7:0]);
  endtask

  task automatic do_read(input logic [11:0] idx);
    logic [15:0] v;
    v = model_rd(idx);
    exp_acc.push_back('{1'b0, idx, 16'h0000});
    exp_tx.push_back(v[15:8]);
    exp_tx.push_back(v[7:0]);
    send_byte({4'h0, idx[11:8]});
    send_byte(idx[7:0]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_acc.size() != 0 || exp_tx.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drained"}, exp_acc.size() + exp_tx.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_reset(input string name);
    chk({name, "_rx_ready"}, rx_ready, 1);
    chk({name, "_tx_valid"}, tx_valid, 0);
    chk({name, "_tx_data"}, tx_data, 0);
    chk({name, "_bus_req"}, bus_req, 0);
    chk({name, "_rd"}, register_read, 0);
    chk({name, "_wr"}, register_write, 0);
    chk({name, "_idx"}, register_index, 0);
    chk({name, "_wval"}, register_write_value, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int g, n_strobe, n_tx;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_reset("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Write 80 01 12 34 with grant held
    do_write(12'h001, 16'h1234);
    drain("write1");
    chk("w1_strobes", strobe_count, 1);
    chk("w1_idx", last_idx, 12'h001);
    chk("w1_val", last_val, 16'h1234);
    chk("w1_latency", last_strobe_cyc - last_acc_cyc, 2);
    chk("w1_ack", tx_log[tx_log.size()-1], 8'hA5);
    chk("w1_mem", rsp_rd(12'h001), 16'h1234);

    // Read 00 02 -> 00 3F
    do_read(12'h002);
    drain("read1");
    chk("r1_strobes", strobe_count, 2);
    chk("r1_idx", last_idx, 12'h002);
    chk("r1_hi", tx_log[tx_log.size()-2], 8'h00);
    chk("r1_lo", tx_log[tx_log.size()-1], 8'h3F);

    // Invalid command 40 -> NAK, no strobe, then a normal read
    exp_tx.push_back(NAK);
    send_byte(8'h40);
    drain("nak");
    chk("nak_byte", tx_log[tx_log.size()-1], 8'h15);
    chk("nak_no_strobe", strobe_count, 2);
    do_read(12'h000);
    drain("after_nak");
    chk("after_nak_hi", tx_log[tx_log.size()-2], 8'h5A);
    chk("after_nak_lo", tx_log[tx_log.size()-1], 8'hC3);

    // Timeout after 80 01 and 16 idle cycles, next frame is a read
    n_strobe = strobe_count;
    n_tx = tx_log.size();
    send_byte(8'h80);
    send_byte(8'h01);
    repeat (TMO) @(posedge clk);
    #1;
    chk("tmo_no_strobe", strobe_count, n_strobe);
    chk("tmo_no_tx", tx_log.size(), n_tx);
    do_read(12'h000);
    drain("after_tmo");
    chk("after_tmo_lo", tx_log[tx_log.size()-1], 8'hC3);

    // Full-width index
    do_write(12'hFFF, 16'h0001);
    drain("write_fff");
    chk("wfff_idx", last_idx, 12'hFFF);
    do_read(12'hFFF);
    drain("read_fff");
    chk("rfff_lo", tx_log[tx_log.size()-1], 8'h01);

    // Stalls: grant delayed 5 cycles, tx_ready low 7 cycles, next frame waiting
    bus_gnt  = 1'b0;
    tx_ready = 1'b0;
    n_strobe = strobe_count;
    do_write(12'h003, 16'hBEEF);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_no_strobe", strobe_count, n_strobe);
    chk("stall_req", bus_req, 1);
    bus_gnt = 1'b1;
    g = cyc;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_strobe_cyc", last_strobe_cyc, g + 1);
    fork
      do_read(12'h003);
    join_none
    chk("stall_tx_valid", tx_valid, 1);
    chk("stall_tx_data", tx_data, 8'hA5);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_tx_data_late", tx_data, 8'hA5);
    chk("stall_rx_ready", rx_ready, 0);
    chk("stall_rx_held", rx_valid, 1);
    tx_ready = 1'b1;
    drain("stall");
    chk("stall_rd_hi", tx_log[tx_log.size()-2], 8'hBE);
    chk("stall_rd_lo", tx_log[tx_log.size()-1], 8'hEF);

    // Reset during the ACCESS cycle of a write
    n_strobe = strobe_count;
    n_tx = tx_log.size();
    send_byte(8'h80);
    send_byte(8'h0A);
    send_byte(8'hCA);
    send_byte(8'hFE);
    @(posedge clk);
    #5;
    chk("rst_in_access", register_write, 1);
    reset_n = 1'b0;
    #1;
    chk_outputs_reset("rst_access");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_strobe", strobe_count, n_strobe);
    chk("rst_no_ack", tx_log.size(), n_tx);
    chk("rst_mem_kept", rsp_rd(12'h00A), 16'h1111);
    do_read(12'h00A);
    drain("after_rst");
    chk("after_rst_lo", tx_log[tx_log.size()-1], 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bus_bridge.md
# reg_bus_bridge

- Byte-stream command bridge that acts as a second initiator on the processor's peripheral register bus.
- Host command frames arrive as bytes from a serial receiver; the bridge requests the bus from the arbiter and issues single-cycle register reads and writes. Read data, ACK and NAK bytes go back to a serial transmitter.
- Bus timing matches the existing register responders: one-cycle strobes, with read data registered by the responder and valid the cycle after `register_read`.

## Interface
- `TIMEOUT_CYCLES`, default 250000: idle cycles allowed between bytes of one frame (10 ms at 25 MHz).
- `ACK_BYTE`, default 8'hA5: response to a completed write.
- `NAK_BYTE`, default 8'h15: response to an invalid command byte.
- `clk` in, 1: system clock (25 MHz domain). One clock; reset is asynchronous and active-low.
- `reset_n` in, 1: asynchronous, active-low reset.
- `rx_data` in, 8: incoming byte.
- `rx_valid` in, 1: `rx_data` valid.
- `rx_ready` out, 1: bridge accepts a byte when `rx_valid & rx_ready`.
- `tx_data` out, 8: outgoing byte.
- `tx_valid` out, 1: `tx_data` valid; held with stable data until accepted.
- `tx_ready` in, 1: transmitter accepts when `tx_valid & tx_ready`.
- `bus_req` out, 1: bus request to the arbiter.
- `bus_gnt` in, 1: bus grant from the arbiter.
- `register_index` out, 12: register address.
- `register_read` out, 1: one-cycle read strobe.
- `register_write` out, 1: one-cycle write strobe.
- `register_write_value` out, 16: write data.
- `register_read_value` in, 16: responder read data, registered by the responder.

## Operation
- Frame byte 0 is the command: bit7 = 1 for write, 0 for read; bits 6:4 must be 0; bits 3:0 = `index[11:8]`.
- Byte 1 = `index[7:0]`.
- A write frame continues with byte 2 = `data[15:8]` and byte 3 = `data[7:0]`.
- States:
  - CMD: on a valid command go to IDX. If bits 6:4 ≠ 0, drop the byte and go to NAK.
  - IDX: go to DHI for a write, REQ for a read.
  - DHI: go to DLO.
  - DLO: go to REQ.
  - REQ: assert `bus_req` and wait for `bus_gnt`.
  - ACCESS: pulse the strobe for one cycle.
  - WAIT_RD: capture `register_read_value`.
  - RESP_HI, RESP_LO: send the captured read data, high byte first.
  - ACK, NAK: send the response byte, then return to CMD.
- After ACCESS, a write goes to ACK and a read goes to WAIT_RD; WAIT_RD goes to RESP_HI.
- `rx_ready` = 1 only in CMD, IDX, DHI and DLO. Bytes arriving in any other state are back-pressured, never dropped.
- `register_index` and `register_write_value` are held stable from REQ through the end of ACCESS.
- `bus_req` is high from REQ through ACCESS (write) or through WAIT_RD (read), then low.
- Inter-byte timeout:
  - The counter runs only in IDX, DHI and DLO and clears on every accepted byte.
  - When the count reaches `TIMEOUT_CYCLES`: go to CMD, issue no strobe, send no response.
  - There is no timeout in REQ; the bridge waits indefinitely for a grant.
- Reset, including mid-frame or mid-ACCESS:
  - State goes to CMD, the partial frame is discarded, and no strobe completes.
  - Reset values: `rx_ready` = 1; all other outputs = 0.

## Timing
- Accepted-byte handshake: in CMD/IDX/DHI/DLO, one byte is consumed per cycle when `rx_valid` is held high.
- Grant to strobe:
  - `bus_gnt` sampled high at the end of a REQ cycle gives ACCESS on the next cycle.
  - Strobe width is exactly 1 cycle.
- Read capture: the strobe is in cycle N (ACCESS), the responder updates at the end of N, and the bridge samples at the end of N+1 (WAIT_RD).
- `tx_valid` rises the cycle after WAIT_RD for a read, or the cycle after ACCESS for a write. The next state is entered the cycle after `tx_ready` is seen.
- Minimum latency from the last frame byte to the strobe is 2 cycles with `bus_gnt` held high.
- A `bus_gnt` drop during ACCESS or WAIT_RD is ignored: the access completes.
- `bus_gnt` is sampled only in REQ.

## Structure
- Shared package `reg_bus_bridge_pkg` holds:
  - the state enum;
  - command field positions (`CMD_WRITE_BIT`, `CMD_RSVD_MSB/LSB`, `CMD_IDX_MSB/LSB`);
  - the default `ACK_BYTE` / `NAK_BYTE` values.
- Sub-module `bridge_timeout`: a loadable cycle counter with `clear`, `enable` and `expired`, with its width derived from `TIMEOUT_CYCLES`.
- The rest is a single FSM with the frame registers in `reg_bus_bridge`.

## Test plan
- Write frame, `bus_gnt`=1: bytes 80, 01, 12, 34 → exactly one `register_write` cycle with index 0x001 and value 0x1234; `bus_req` returns low; then `tx_data`=A5.
- Read frame: bytes 00, 02, responder model returns 0x003F → one `register_read` cycle with index 0x002; then `tx` sends 00 followed by 3F; `bus_req` is low after WAIT_RD.
- Invalid command: byte 40 → `tx` NAK 15 and no strobe. A following frame 00, 00 completes normally.
- Timeout with `TIMEOUT_CYCLES`=16: bytes 80, 01, then 16 idle cycles → back to CMD, no strobe, no tx. A next read frame 00, 00 works.
- Stalls: grant delayed 5 cycles and `tx_ready` held low for 7 cycles → the strobe fires the cycle after the grant; `tx_data` and `tx_valid` stay stable while stalled; `rx_ready` = 0 throughout.
- Reset asserted during ACCESS of a write → all outputs 0 immediately (`rx_ready` = 1), no second strobe, and no ACK after release.
